rs_alu: RTL and testbench

Arithmetic reservation station with an integrated single-cycle ALU. It accepts issued non-memory instructions from the reorder buffer together with renamed operands (value or ROB-entry tag), snoops the common data bus until operands are ready, and executes one ready instruction per cycle. Each result, plus the branch/jump redirect information, is broadcast on the ALU CDB port back to the ROB and to the load/store buffer. Loads and stores never enter this block.

---
 rtl/rs_alu_pkg.sv | 57 +++++
 rtl/rs_alu_if.sv | 50 +++++
 rtl/rs_alu_alu.sv | 87 ++++++++
 rtl/rs_alu.sv | 196 +++++++++++++++++++
 tb/tb_rs_alu.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_alu_pkg.sv
// -----------------------------------------------------------------------------
// rs_alu_pkg
// Shared definitions for the arithmetic reservation station: default tag and
// opcode widths, and the internal opcode codes used by the ROB, the
// load/store buffer and this station.
// -----------------------------------------------------------------------------
package rs_alu_pkg;

    localparam int DEF_ENTRY_W = 4;
    localparam int DEF_OP_W    = 6;

    // Internal opcode codes. Code 0 is never issued here.
    typedef enum logic [DEF_OP_W-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,
        OP_BLTU  = 6'd9,
        OP_BGEU  = 6'd10,
        OP_ADDI  = 6'd11,
        OP_SLTI  = 6'd12,
        OP_SLTIU = 6'd13,
        OP_XORI  = 6'd14,
        OP_ORI   = 6'd15,
        OP_ANDI  = 6'd16,
        OP_SLLI  = 6'd17,
        OP_SRLI  = 6'd18,
        OP_SRAI  = 6'd19,
        OP_ADD   = 6'd20,
        OP_SUB   = 6'd21,
        OP_SLL   = 6'd22,
        OP_SLT   = 6'd23,
        OP_SLTU  = 6'd24,
        OP_XOR   = 6'd25,
        OP_SRL   = 6'd26,
        OP_SRA   = 6'd27,
        OP_OR    = 6'd28,
        OP_AND   = 6'd29
    } op_e;

    // Conditional branches: no rd value, redirect only when taken.
    function automatic logic is_branch(input op_e op);
        return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    endfunction

    // OP-IMM group: the immediate replaces rs2 as the second ALU operand.
    function automatic logic is_imm_op(input op_e op);
        return op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
                          OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI};
    endfunction

endpackage

// File: rtl/rs_alu_if.sv
// -----------------------------------------------------------------------------
// rs_alu_if
// Bundle between the reservation station and its neighbours.
//   issue_*      : instruction + renamed operands from the ROB
//   rs_full      : all station slots busy (issue refused)
//   lsb_cdb_*    : load result broadcast from the load/store buffer
//   cdb_*        : ALU result broadcast (value + redirect information)
// master = ROB/LSB side, slave = reservation station.
// -----------------------------------------------------------------------------
interface rs_alu_if #(
    parameter int ENTRY_W = 4,
    parameter int OP_W    = 6
);
    logic               issue_valid;
    logic [ENTRY_W-1:0] issue_entry;
    logic [OP_W-1:0]    issue_op;
    logic [31:0]        issue_pc;
    logic [31:0]        issue_vj;
    logic [31:0]        issue_vk;
    logic [ENTRY_W-1:0] issue_qj;
    logic [ENTRY_W-1:0] issue_qk;
    logic [31:0]        issue_imm;
    logic               rs_full;

    logic               lsb_cdb_valid;
    logic [ENTRY_W-1:0] lsb_cdb_entry;
    logic [31:0]        lsb_cdb_value;

    logic               cdb_valid;
    logic [ENTRY_W-1:0] cdb_entry;
    logic [31:0]        cdb_value;
    logic               cdb_pc_change;
    logic [31:0]        cdb_pc_target;

    modport master (
        output issue_valid, issue_entry, issue_op, issue_pc, issue_vj,
               issue_vk, issue_qj, issue_qk, issue_imm,
        output lsb_cdb_valid, lsb_cdb_entry, lsb_cdb_value,
        input  rs_full,
        input  cdb_valid, cdb_entry, cdb_value, cdb_pc_change, cdb_pc_target
    );

    modport slave (
        input  issue_valid, issue_entry, issue_op, issue_pc, issue_vj,
               issue_vk, issue_qj, issue_qk, issue_imm,
        input  lsb_cdb_valid, lsb_cdb_entry, lsb_cdb_value,
        output rs_full,
        output cdb_valid, cdb_entry, cdb_value, cdb_pc_change, cdb_pc_target
    );
endinterface

// File: rtl/rs_alu_alu.sv
// -----------------------------------------------------------------------------
// rs_alu_alu
// Single-cycle combinational ALU for the reservation station.
//   op        : internal opcode code
//   vj, vk    : rs1 / rs2 values
//   imm, pc   : sign-extended immediate, instruction PC
//   value     : rd value (0 for branches)
//   pc_change : JAL/JALR or taken branch
//   pc_target : redirect target (pc+4 when a branch falls through)
// -----------------------------------------------------------------------------
module rs_alu_alu
    import rs_alu_pkg::*;
(
    input  logic [DEF_OP_W-1:0] op,
    input  logic [31:0]         vj,
    input  logic [31:0]         vk,
    input  logic [31:0]         imm,
    input  logic [31:0]         pc,
    output logic [31:0]         value,
    output logic                pc_change,
    output logic [31:0]         pc_target
);

    op_e         code;
    logic [31:0] src2;
    logic [4:0]  shamt;
    logic [31:0] seq_pc;
    logic        lt_s;
    logic        lt_u;
    logic        taken;

    // NOTE: every variable driven here gets a default before the case so
    // that no path leaves it unassigned and no latch is inferred.
    always_comb begin
        code      = op_e'(op);
        src2      = is_imm_op(code) ? imm : vk;
        shamt     = src2[4:0];
        seq_pc    = pc + 32'd4;
        lt_s      = $signed(vj) < $signed(src2);
        lt_u      = vj < src2;
        taken     = 1'b0;
        value     = '0;
        pc_change = 1'b0;
        pc_target = seq_pc;

        case (code)
            OP_LUI:   value = imm;
            OP_AUIPC: value = pc + imm;
            OP_JAL: begin
                value     = seq_pc;
                pc_change = 1'b1;
                pc_target = pc + imm;
            end
            OP_JALR: begin
                value     = seq_pc;
                pc_change = 1'b1;
                pc_target = (vj + imm) & ~32'd1;
            end
            OP_BEQ:            taken = (vj == vk);
            OP_BNE:            taken = (vj != vk);
            OP_BLT:            taken = lt_s;
            OP_BGE:            taken = !lt_s;
            OP_BLTU:           taken = lt_u;
            OP_BGEU:           taken = !lt_u;
            OP_ADD,  OP_ADDI:  value = vj + src2;
            OP_SUB:            value = vj - src2;
            OP_SLT,  OP_SLTI:  value = {31'd0, lt_s};
            OP_SLTU, OP_SLTIU: value = {31'd0, lt_u};
            OP_XOR,  OP_XORI:  value = vj ^ src2;
            OP_OR,   OP_ORI:   value = vj | src2;
            OP_AND,  OP_ANDI:  value = vj & src2;
            OP_SLL,  OP_SLLI:  value = vj << shamt;
            OP_SRL,  OP_SRLI:  value = vj >> shamt;
            OP_SRA,  OP_SRAI:  value = $signed(vj) >>> shamt;
            default:           value = '0;
        endcase

        // Branches redirect only when taken; pc_target already holds pc+4.
        if (is_branch(code)) begin
            pc_change = taken;
            if (taken) begin
                pc_target = pc + imm;
            end
        end
    end

endmodule

// File: rtl/rs_alu.sv
// -----------------------------------------------------------------------------
// rs_alu
// Arithmetic reservation station with an integrated single-cycle ALU.
// Holds up to RS_SIZE renamed instructions, snoops both CDBs for missing
// operands and executes the lowest-index ready slot each cycle, registering
// the result onto its own CDB.
//   clk_in   : clock, rising edge
//   rst_n_in : synchronous active-low reset
//   rdy_in   : global ready; low freezes every register
//   flush_in : mispredict flush; empties the station and the CDB output
//   bus      : issue / lsb_cdb inputs, rs_full and cdb_* outputs
// -----------------------------------------------------------------------------
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int RS_SIZE = 8,
    parameter int ENTRY_W = DEF_ENTRY_W,
    parameter int OP_W    = DEF_OP_W
) (
    input  logic    clk_in,
    input  logic    rst_n_in,
    input  logic    rdy_in,
    input  logic    flush_in,
    rs_alu_if.slave bus
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // One renamed source operand: tag 0 means the value is valid.
    typedef struct packed {
        logic [ENTRY_W-1:0] q;
        logic [31:0]        v;
    } opnd_t;

    // Slot array
    logic [RS_SIZE-1:0] busy;
    logic [OP_W-1:0]    op_q    [RS_SIZE];
    logic [ENTRY_W-1:0] entry_q [RS_SIZE];
    logic [31:0]        pc_q    [RS_SIZE];
    logic [31:0]        imm_q   [RS_SIZE];
    opnd_t              j_q     [RS_SIZE];
    opnd_t              k_q     [RS_SIZE];

    // Registered CDB output
    logic               cdb_valid_q;
    logic [ENTRY_W-1:0] cdb_entry_q;
    logic [31:0]        cdb_value_q;
    logic               cdb_pc_change_q;
    logic [31:0]        cdb_pc_target_q;

    // Load/store buffer broadcast
    logic               lsb_valid;
    logic [ENTRY_W-1:0] lsb_entry;
    logic [31:0]        lsb_value;

    logic [RS_SIZE-1:0] ready;
    logic [IDX_W-1:0]   free_idx;
    logic               free_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic               accept;

    logic [31:0]        alu_value;
    logic               alu_pc_change;
    logic [31:0]        alu_pc_target;

    assign lsb_valid = bus.lsb_cdb_valid;
    assign lsb_entry = bus.lsb_cdb_entry;
    assign lsb_value = bus.lsb_cdb_value;

    // Busy vector only: a slot being freed this cycle is not visible yet.
    assign bus.rs_full = &busy;

    // Capture a value from whichever CDB carries the operand's tag. The own
    // CDB is the registered output, so a consumer woken by it becomes ready
    // one cycle after the broadcast.
    function automatic opnd_t resolve(input opnd_t o);
        opnd_t r;
        r = o;
        if (o.q != '0) begin
            if (cdb_valid_q && (cdb_entry_q == o.q)) begin
                r.q = '0;
                r.v = cdb_value_q;
            end else if (lsb_valid && (lsb_entry == o.q)) begin
                r.q = '0;
                r.v = lsb_value;
            end
        end
        return r;
    endfunction

    // Lowest-index free slot and lowest-index ready slot. Scanning downward
    // lets the last hit (the lowest index) win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy[i] && (j_q[i].q == '0) && (k_q[i].q == '0);
        end
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // free_found is exactly !rs_full.
    assign accept = bus.issue_valid && free_found;

    rs_alu_alu u_alu (
        .op        (op_q[sel_idx]),
        .vj        (j_q[sel_idx].v),
        .vk        (k_q[sel_idx].v),
        .imm       (imm_q[sel_idx]),
        .pc        (pc_q[sel_idx]),
        .value     (alu_value),
        .pc_change (alu_pc_change),
        .pc_target (alu_pc_target)
    );

    // Control state: busy flags and the CDB output register.
    // NOTE: sequential state uses non-blocking assignments so every block
    // sees the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            busy            <= '0;
            cdb_valid_q     <= 1'b0;
            cdb_entry_q     <= '0;
            cdb_value_q     <= '0;
            cdb_pc_change_q <= 1'b0;
            cdb_pc_target_q <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                busy            <= '0;
                cdb_valid_q     <= 1'b0;
                cdb_entry_q     <= '0;
                cdb_value_q     <= '0;
                cdb_pc_change_q <= 1'b0;
                cdb_pc_target_q <= '0;
            end else begin
                // The selected slot is busy and the issue slot is free, so
                // the two updates never touch the same bit.
                if (sel_found) begin
                    busy[sel_idx]   <= 1'b0;
                    cdb_valid_q     <= 1'b1;
                    cdb_entry_q     <= entry_q[sel_idx];
                    cdb_value_q     <= alu_value;
                    cdb_pc_change_q <= alu_pc_change;
                    cdb_pc_target_q <= alu_pc_target;
                end else begin
                    cdb_valid_q     <= 1'b0;
                end
                if (accept) begin
                    busy[free_idx] <= 1'b1;
                end
            end
        end
    end

    // Slot payload: wakeup of busy slots and the write of a newly issued
    // instruction (with same-cycle forwarding from either CDB).
    // NOTE: the payload is not reset; busy alone qualifies it, so stale
    // contents of a free slot are never observed.
    always_ff @(posedge clk_in) begin
        if (rst_n_in && rdy_in && !flush_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    j_q[i] <= resolve(j_q[i]);
                    k_q[i] <= resolve(k_q[i]);
                end
            end
            if (accept) begin
                op_q[free_idx]    <= bus.issue_op;
                entry_q[free_idx] <= bus.issue_entry;
                pc_q[free_idx]    <= bus.issue_pc;
                imm_q[free_idx]   <= bus.issue_imm;
                j_q[free_idx]     <= resolve('{q: bus.issue_qj, v: bus.issue_vj});
                k_q[free_idx]     <= resolve('{q: bus.issue_qk, v: bus.issue_vk});
            end
        end
    end

    assign bus.cdb_valid     = cdb_valid_q;
    assign bus.cdb_entry     = cdb_entry_q;
    assign bus.cdb_value     = cdb_value_q;
    assign bus.cdb_pc_change = cdb_pc_change_q;
    assign bus.cdb_pc_target = cdb_pc_target_q;

endmodule

// File: tb/tb_rs_alu.sv
// -----------------------------------------------------------------------------
// tb_rs_alu
// Self-checking bench for rs_alu: reset, a table of single-instruction
// vectors, hand-written dependency / forwarding / full / flush / stall
// sequences, and a randomized phase against a reference model.
// -----------------------------------------------------------------------------
module tb_rs_alu;
    import rs_alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    logic flush;

    always #5 clk = ~clk;

    rs_alu_if #(.ENTRY_W(4), .OP_W(6)) bus ();

    rs_alu #(.RS_SIZE(8), .ENTRY_W(4), .OP_W(6)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .flush_in (flush),
        .bus      (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        op_e         op;
        logic [31:0] pc, vj, vk, imm;
        logic [31:0] value;
        logic        change;
        logic [31:0] target;
        logic        chk_tgt;
    } vec_t;

    typedef struct {
        logic [3:0]  entry;
        logic [31:0] value;
        logic        change;
        logic [31:0] target;
        logic        chk_tgt;
    } exp_t;

    vec_t vecs[16];
    exp_t exp_q[$];
    bit   prev_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_issue();
        bus.issue_valid = 1'b0;
        bus.issue_entry = '0;
        bus.issue_op    = '0;
        bus.issue_pc    = '0;
        bus.issue_vj    = '0;
        bus.issue_vk    = '0;
        bus.issue_qj    = '0;
        bus.issue_qk    = '0;
        bus.issue_imm   = '0;
    endtask

    task automatic clear_lsb();
        bus.lsb_cdb_valid = 1'b0;
        bus.lsb_cdb_entry = '0;
        bus.lsb_cdb_value = '0;
    endtask

    task automatic lsb(input logic [3:0] entry, input logic [31:0] value);
        bus.lsb_cdb_valid = 1'b1;
        bus.lsb_cdb_entry = entry;
        bus.lsb_cdb_value = value;
    endtask

    task automatic issue(input op_e op, input logic [3:0] entry, input logic [31:0] pc,
                         input logic [31:0] vj, input logic [3:0] qj,
                         input logic [31:0] vk, input logic [3:0] qk,
                         input logic [31:0] imm);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_entry = entry;
        bus.issue_pc    = pc;
        bus.issue_vj    = vj;
        bus.issue_qj    = qj;
        bus.issue_vk    = vk;
        bus.issue_qk    = qk;
        bus.issue_imm   = imm;
    endtask

    task automatic expect_bc(input string name, input logic [3:0] entry, input logic [31:0] value);
        check({name, "_valid"}, 32'(bus.cdb_valid), 32'd1);
        check({name, "_entry"}, 32'(bus.cdb_entry), 32'(entry));
        check({name, "_value"}, bus.cdb_value, value);
    endtask

    // Reference model written from the instruction semantics.
    function automatic exp_t ref_alu(input op_e op, input logic [3:0] entry,
                                     input logic [31:0] pc, input logic [31:0] a,
                                     input logic [31:0] rs2, input logic [31:0] imm);
        exp_t        e;
        logic [31:0] b;
        int          sh;
        bit          taken;
        b = (op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
                        OP_SLLI, OP_SRLI, OP_SRAI}) ? imm : rs2;
        sh = int'(b % 32);
        e.entry   = entry;
        e.value   = 32'd0;
        e.change  = 1'b0;
        e.target  = pc + 4;
        e.chk_tgt = 1'b0;
        taken     = 1'b0;
        case (op)
            OP_LUI:   e.value = imm;
            OP_AUIPC: e.value = pc + imm;
            OP_JAL:   begin e.value = pc + 4; e.change = 1; e.target = pc + imm; e.chk_tgt = 1; end
            OP_JALR:  begin e.value = pc + 4; e.change = 1; e.target = {a[31:1] + imm[31:1] + 31'(a[0] & imm[0]), 1'b0}; e.chk_tgt = 1; end
            OP_BEQ:   taken = (a == rs2);
            OP_BNE:   taken = (a != rs2);
            OP_BLT:   taken = ($signed(a) < $signed(rs2));
            OP_BGE:   taken = !($signed(a) < $signed(rs2));
            OP_BLTU:  taken = (a < rs2);
            OP_BGEU:  taken = (a >= rs2);
            OP_ADD, OP_ADDI:   e.value = a + b;
            OP_SUB:            e.value = a - b;
            OP_SLT, OP_SLTI:   e.value = ($signed(a) < $signed(b)) ? 1 : 0;
            OP_SLTU, OP_SLTIU: e.value = (a < b) ? 1 : 0;
            OP_XOR, OP_XORI:   e.value = a ^ b;
            OP_OR, OP_ORI:     e.value = a | b;
            OP_AND, OP_ANDI:   e.value = a & b;
            OP_SLL, OP_SLLI:   e.value = a << sh;
            OP_SRL, OP_SRLI:   e.value = a >> sh;
            OP_SRA, OP_SRAI:   e.value = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            default:           e.value = 32'd0;
        endcase
        if (op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU}) begin
            e.chk_tgt = 1'b1;
            e.change  = taken;
            e.target  = taken ? pc + imm : pc + 4;
        end
        return e;
    endfunction

    // Compare one fresh broadcast against the scoreboard head.
    task automatic monitor();
        exp_t e;
        if (prev_rdy && bus.cdb_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_unexpected: got broadcast entry %0d expected none", bus.cdb_entry);
            end else begin
                e = exp_q.pop_front();
                check("rand_entry", 32'(bus.cdb_entry), 32'(e.entry));
                check("rand_value", bus.cdb_value, e.value);
                check("rand_change", 32'(bus.cdb_pc_change), 32'(e.change));
                if (e.chk_tgt) check("rand_target", bus.cdb_pc_target, e.target);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stale;
        op_e rop;
        logic [31:0] rvj;

        vecs[0]  = '{OP_ADDI,  32'h0,     32'd5,         32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 32'h0,     1'b0};
        vecs[1]  = '{OP_BLT,   32'h100,   32'hFFFF_FFFF, 32'd1,         32'h20,        32'h0,         1'b1, 32'h120,   1'b1};
        vecs[2]  = '{OP_BLTU,  32'h100,   32'hFFFF_FFFF, 32'd1,         32'h20,        32'h0,         1'b0, 32'h104,   1'b1};
        vecs[3]  = '{OP_JALR,  32'h100,   32'h203,       32'd0,         32'h0,         32'h104,       1'b1, 32'h202,   1'b1};
        vecs[4]  = '{OP_LUI,   32'h0,     32'd0,         32'd0,         32'h1234_5000, 32'h1234_5000, 1'b0, 32'h0,     1'b0};
        vecs[5]  = '{OP_AUIPC, 32'h1000,  32'd0,         32'd0,         32'h2000,      32'h3000,      1'b0, 32'h0,     1'b0};
        vecs[6]  = '{OP_JAL,   32'h40,    32'd0,         32'd0,         32'h10,        32'h44,        1'b1, 32'h50,    1'b1};
        vecs[7]  = '{OP_SUB,   32'h0,     32'd3,         32'd5,         32'h0,         32'hFFFF_FFFE, 1'b0, 32'h0,     1'b0};
        vecs[8]  = '{OP_SRA,   32'h0,     32'h8000_0000, 32'h24,        32'h0,         32'hF800_0000, 1'b0, 32'h0,     1'b0};
        vecs[9]  = '{OP_SLTU,  32'h0,     32'd1,         32'hFFFF_FFFF, 32'h0,         32'd1,         1'b0, 32'h0,     1'b0};
        vecs[10] = '{OP_SLT,   32'h0,     32'd1,         32'hFFFF_FFFF, 32'h0,         32'd0,         1'b0, 32'h0,     1'b0};
        vecs[11] = '{OP_BEQ,   32'h200,   32'd7,         32'd7,         32'hFFFF_FFF8, 32'h0,         1'b1, 32'h1F8,   1'b1};
        vecs[12] = '{OP_SRLI,  32'h0,     32'h8000_0000, 32'd0,         32'h1F,        32'd1,         1'b0, 32'h0,     1'b0};
        vecs[13] = '{OP_BGE,   32'h300,   32'hFFFF_FFFF, 32'd1,         32'h40,        32'h0,         1'b0, 32'h304,   1'b1};
        vecs[14] = '{OP_XORI,  32'h0,     32'hF0F0_F0F0, 32'd0,         32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0, 32'h0,     1'b0};
        vecs[15] = '{OP_SLLI,  32'h0,     32'd1,         32'd0,         32'h3F,        32'h8000_0000, 1'b0, 32'h0,     1'b0};

        // ---------------- reset with an issue presented ----------------
        rst_n = 1'b0;
        rdy   = 1'b1;
        flush = 1'b0;
        clear_lsb();
        issue(OP_ADDI, 4'd3, 32'h0, 32'd1, 4'd0, 32'd0, 4'd0, 32'd1);
        tick();
        tick();
        check("rst_valid",  32'(bus.cdb_valid), 32'd0);
        check("rst_entry",  32'(bus.cdb_entry), 32'd0);
        check("rst_value",  bus.cdb_value, 32'd0);
        check("rst_change", 32'(bus.cdb_pc_change), 32'd0);
        check("rst_target", bus.cdb_pc_target, 32'd0);
        check("rst_full",   32'(bus.rs_full), 32'd0);
        rst_n = 1'b1;
        clear_issue();
        stale = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.cdb_valid) stale++;
        end
        check("rst_no_broadcast", 32'(stale), 32'd0);

        // ---------------- table of ready single instructions ----------------
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, 4'((i % 10) + 1), vecs[i].pc, vecs[i].vj, 4'd0,
                  vecs[i].vk, 4'd0, vecs[i].imm);
            tick();
            clear_issue();
            check($sformatf("vec%0d_early", i), 32'(bus.cdb_valid), 32'd0);
            tick();
            expect_bc($sformatf("vec%0d", i), 4'((i % 10) + 1), vecs[i].value);
            check($sformatf("vec%0d_change", i), 32'(bus.cdb_pc_change), 32'(vecs[i].change));
            if (vecs[i].chk_tgt)
                check($sformatf("vec%0d_target", i), bus.cdb_pc_target, vecs[i].target);
            tick();
            check($sformatf("vec%0d_oneshot", i), 32'(bus.cdb_valid), 32'd0);
        end

        // ---------------- lsb wakeup ----------------
        issue(OP_ADD, 4'd4, 32'h0, 32'd0, 4'd2, 32'd10, 4'd0, 32'd0);
        tick();
        clear_issue();
        tick();
        check("dep_blocked", 32'(bus.cdb_valid), 32'd0);
        lsb(4'd2, 32'd7);
        tick();
        clear_lsb();
        check("dep_wake_cycle", 32'(bus.cdb_valid), 32'd0);
        tick();
        expect_bc("dep", 4'd4, 32'd17);

        // ---------------- issue-time forwarding from lsb ----------------
        issue(OP_ADD, 4'd5, 32'h0, 32'd0, 4'd2, 32'd10, 4'd0, 32'd0);
        lsb(4'd2, 32'd7);
        tick();
        clear_issue();
        clear_lsb();
        tick();
        expect_bc("fwd_lsb", 4'd5, 32'd17);
        tick();

        // ---------------- both CDBs wake one slot ----------------
        issue(OP_ADD, 4'd6, 32'h0, 32'd0, 4'd1, 32'd0, 4'd2, 32'd0);
        tick();
        issue(OP_ADDI, 4'd1, 32'h0, 32'd40, 4'd0, 32'd0, 4'd0, 32'd0);
        tick();
        clear_issue();
        tick();
        expect_bc("dual_prod", 4'd1, 32'd40);
        lsb(4'd2, 32'd2);
        tick();
        clear_lsb();
        check("dual_wake_cycle", 32'(bus.cdb_valid), 32'd0);
        tick();
        expect_bc("dual", 4'd6, 32'd42);
        tick();

        // ---------------- own-CDB chain, forwarding and priority ----------------
        issue(OP_ADDI, 4'd1, 32'h0, 32'd1, 4'd0, 32'd0, 4'd0, 32'd1);
        tick();
        issue(OP_ADDI, 4'd2, 32'h0, 32'd0, 4'd1, 32'd0, 4'd0, 32'd10);
        tick();
        expect_bc("chain_p", 4'd1, 32'd2);
        issue(OP_ADDI, 4'd3, 32'h0, 32'd0, 4'd1, 32'd0, 4'd0, 32'd100);
        tick();
        clear_issue();
        check("chain_gap", 32'(bus.cdb_valid), 32'd0);
        tick();
        expect_bc("chain_fwd", 4'd3, 32'd102);
        tick();
        expect_bc("chain_c", 4'd2, 32'd12);
        tick();
        check("chain_end", 32'(bus.cdb_valid), 32'd0);

        // ---------------- full / refused issue / flush ----------------
        for (int k = 0; k < 8; k++) begin
            issue(OP_ADD, 4'(k + 1), 32'h0, 32'd0, (k == 0) ? 4'd9 : 4'd10,
                  (k == 0) ? 32'h100 : 32'd0, 4'd0, 32'd0);
            tick();
        end
        check("full_set", 32'(bus.rs_full), 32'd1);
        issue(OP_ADDI, 4'd12, 32'h0, 32'd55, 4'd0, 32'd0, 4'd0, 32'd0);
        tick();
        clear_issue();
        check("full_hold", 32'(bus.rs_full), 32'd1);
        check("full_no_bc", 32'(bus.cdb_valid), 32'd0);
        lsb(4'd9, 32'h1000);
        tick();
        clear_lsb();
        check("full_wake_cycle", 32'(bus.cdb_valid), 32'd0);
        tick();
        expect_bc("full_release", 4'd1, 32'h1100);
        check("full_freed", 32'(bus.rs_full), 32'd0);
        issue(OP_ADD, 4'd13, 32'h0, 32'd0, 4'd10, 32'd0, 4'd0, 32'd0);
        tick();
        check("full_refill", 32'(bus.rs_full), 32'd1);
        check("full_refill_bc", 32'(bus.cdb_valid), 32'd0);
        issue(OP_ADDI, 4'd14, 32'h0, 32'd3, 4'd0, 32'd0, 4'd0, 32'd0);
        lsb(4'd10, 32'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_issue();
        clear_lsb();
        check("flush_full", 32'(bus.rs_full), 32'd0);
        check("flush_valid", 32'(bus.cdb_valid), 32'd0);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.cdb_valid) stale++;
        end
        check("flush_no_stale", 32'(stale), 32'd0);

        // ---------------- rdy_in stall mid-broadcast ----------------
        for (int k = 0; k < 3; k++) begin
            issue(OP_ADD, 4'(k + 1), 32'h0, 32'd0, 4'd5, 32'(k + 1), 4'd0, 32'd0);
            tick();
        end
        clear_issue();
        lsb(4'd5, 32'd100);
        tick();
        clear_lsb();
        tick();
        expect_bc("stall_a", 4'd1, 32'd101);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_bc($sformatf("stall_hold%0d", i), 4'd1, 32'd101);
        end
        rdy = 1'b1;
        tick();
        expect_bc("stall_b", 4'd2, 32'd102);
        tick();
        expect_bc("stall_c", 4'd3, 32'd103);
        tick();
        check("stall_end", 32'(bus.cdb_valid), 32'd0);

        // ---------------- randomized ready instructions ----------------
        prev_rdy = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            monitor();
            rdy = (cyc % 17 == 5) ? 1'b0 : ($urandom_range(0, 7) != 0);
            if (cyc < 380 && $urandom_range(0, 3) != 0) begin
                rop = op_e'($urandom_range(1, 29));
                rvj = $urandom;
                issue(rop, 4'($urandom_range(1, 10)), $urandom & 32'hFFFF_FFFC, rvj, 4'd0,
                      ($urandom_range(0, 3) == 0) ? rvj : $urandom, 4'd0,
                      ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom);
                if (rdy) exp_q.push_back(ref_alu(rop, bus.issue_entry, bus.issue_pc,
                                                 bus.issue_vj, bus.issue_vk, bus.issue_imm));
            end else begin
                clear_issue();
            end
            prev_rdy = rdy;
            tick();
        end
        clear_issue();
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            monitor();
            prev_rdy = 1'b1;
            tick();
        end
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
